ni_flit_sink: RTL

Receive-side network interface endpoint that consumes flits from the router's local output port (tx_l_data/tx_l_valid) over the valid/busy handshake. Buffers flits in a small FIFO and checks each one for correct destination, non-null header and per-source sequence continuity. Maintains a delivered-flit counter, a sticky error flag and a heartbeat LED. Sits beside the traffic source inside each node and closes the local loop of the NI.

---
 rtl/ni_flit_sink_pkg.sv | 25 ++
 rtl/ni_sink_fifo.sv | 48 ++++
 rtl/ni_flit_sink.sv | 96 +++++++++
 3 files changed

// File: rtl/ni_flit_sink_pkg.sv
// Shared flit layout, null-header and error-code encodings for the NI receive endpoint.
package ni_flit_sink_pkg;
   localparam int HDR_SZ  = 4;
   localparam int PL_SZ   = 16;
   localparam int ADDR_SZ = 4;

   // flit = {hdr, payload, addr}; payload = {src, seq}
   localparam int ADDR_LSB = 0;
   localparam int PL_LSB   = ADDR_SZ;
   localparam int HDR_LSB  = ADDR_SZ + PL_SZ;
   localparam int SEQ_SZ   = PL_SZ - ADDR_SZ;
   localparam int SEQ_LSB  = PL_LSB;
   localparam int SRC_LSB  = PL_LSB + SEQ_SZ;

   localparam logic [HDR_SZ-1:0] HDR_NULL = '0;
   localparam logic [15:0]       LFSR_SEED = 16'hACE1;
   localparam logic [19:0]       CNT_MAX   = 20'hFFFFF;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISROUTE = 2'b01,
      ERR_SEQ      = 2'b10,
      ERR_NULL     = 2'b11
   } err_code_t;
endpackage

// File: rtl/ni_sink_fifo.sv
// Receive buffer for ni_flit_sink: synchronous FIFO, power-of-two depth, async active-low reset.
module ni_sink_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ni_flit_sink.sv
// NI receive endpoint: buffers local-port flits, checks dest/header/per-source sequence,
// counts and flags errors. Define BACKPRESSURE_TEST_EN to add LFSR-driven random busy stalls.
module ni_flit_sink
   import ni_flit_sink_pkg::*;
#(
   parameter int ID         = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int LED_DIV    = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0] item_in,
   input  logic                          valid,
   output logic                          busy,
   output logic [19:0]                   flit_counter,
   output logic                          error,
   output logic [1:0]                    err_code,
   output logic                          led
);
   localparam int FLIT_W = HDR_SZ + PL_SZ + ADDR_SZ;
   localparam int NSRC   = 1 << ADDR_SZ;

   logic [FLIT_W-1:0]  head;
   logic               fifo_full, fifo_empty, pop;
   logic [HDR_SZ-1:0]  hdr;
   logic [ADDR_SZ-1:0] addr, src;
   logic [SEQ_SZ-1:0]  seq;
   err_code_t          code;
   logic [19:0]        cnt_inc;
   logic [NSRC-1:0]    seen;
   logic [SEQ_SZ-1:0]  exp_tbl [NSRC];

`ifdef BACKPRESSURE_TEST_EN
   logic [15:0] lfsr;
   logic        stall;
   assign stall = (lfsr[1:0] == 2'b00);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr <= LFSR_SEED;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
   assign busy = fifo_full | stall;
`else
   assign busy = fifo_full;
`endif

   ni_sink_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (valid && !busy),
      .din   (item_in),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The checker drains one flit per cycle whenever anything is buffered.
   assign pop  = !fifo_empty;
   assign hdr  = head[HDR_LSB +: HDR_SZ];
   assign addr = head[ADDR_LSB +: ADDR_SZ];
   assign src  = head[SRC_LSB +: ADDR_SZ];
   assign seq  = head[SEQ_LSB +: SEQ_SZ];
   assign cnt_inc = flit_counter + 20'd1;

   always_comb begin
      code = ERR_NONE;
      if (hdr == HDR_NULL)                            code = ERR_NULL;
      else if (addr != ADDR_SZ'(ID))                  code = ERR_MISROUTE;
      else if (seen[src] && (seq != exp_tbl[src]))    code = ERR_SEQ;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flit_counter <= '0;
         error        <= 1'b0;
         err_code     <= ERR_NONE;
         led          <= 1'b0;
         seen         <= '0;
         for (int i = 0; i < NSRC; i++) exp_tbl[i] <= '0;
      end else if (pop) begin
         // Table resyncs on every non-null flit, even ones that failed the check.
         if (hdr != HDR_NULL) begin
            seen[src]    <= 1'b1;
            exp_tbl[src] <= seq + 1'b1;
         end
         if (flit_counter != CNT_MAX) begin
            flit_counter <= cnt_inc;
            if (cnt_inc[LED_DIV-1:0] == '0) led <= ~led;
         end
         if (!error && (code != ERR_NONE)) begin
            error    <= 1'b1;
            err_code <= code;
         end
      end
   end
endmodule
